pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined RISC-V core. Drives the enable inputs of the IF/ID/EX/MEM/WB pipeline registers, the PC enable and the bubble-insert (flush) controls from hazard, branch and memory/multiply-divide handshake inputs. It is the only block allowed to drive pipeline-register enables. It also detects data-memory timeouts and counts fetch-stall cycles for performance monitoring.

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Central stall/flush sequencer for the 5-stage RISC-V pipeline.
//            Sole driver of the IF/ID/EX/MEM/WB register enables, the PC
//            enable and the bubble-insert (flush) controls. Also flags
//            data-memory timeouts and counts fetch-stall cycles.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   core clock, rising edge
//   resetn           in   asynchronous active-low reset
//   load_use_hazard  in   ID needs the result of the load now in EX
//   branch_taken     in   EX resolved a taken branch/jump
//   imem_ready       in   fetch data valid this cycle
//   dmem_req         in   MEM-stage instruction is a load/store
//   dmem_ready       in   data memory completes the access this cycle
//   md_start         in   EX holds a mul/div instruction
//   md_done          in   mul/div result valid (held until EX advances)
//   en_if..en_wb     out  pipeline register enables (en_if = PC enable)
//   flush_id/ex/mem  out  load a bubble into that register
//   bus_error        out  sticky data-memory timeout flag
//   stall_cycles     out  saturating count of cycles with en_if = 0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_use_hazard,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    input  logic             md_start,
    input  logic             md_done,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             flush_id,
    output logic             flush_ex,
    output logic             flush_mem,
    output logic             bus_error,
    output logic [CNT_W-1:0] stall_cycles
);

    // State encoding
    localparam logic [1:0] c_st_run  = 2'd0;
    localparam logic [1:0] c_st_dmem = 2'd1;
    localparam logic [1:0] c_st_md   = 2'd2;
    localparam logic [1:0] c_st_err  = 2'd3;

    // Control vector layout: {en_if, en_id, en_ex, en_mem, en_wb,
    //                         flush_id, flush_ex, flush_mem}
    localparam logic [7:0] c_ctl_freeze  = 8'b00000_000;
    localparam logic [7:0] c_ctl_mdstall = 8'b00011_001;
    localparam logic [7:0] c_ctl_branch  = 8'b11111_110;
    localparam logic [7:0] c_ctl_loaduse = 8'b00111_010;
    localparam logic [7:0] c_ctl_fetch   = 8'b01111_100;
    localparam logic [7:0] c_ctl_advance = 8'b11111_000;

    // wait_cnt value seen on the last tolerated not-ready DMEM_WAIT cycle
    localparam logic [7:0]       c_timeout_last = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic             r_ret_md;
    logic [7:0]       r_wait_cnt;
    logic             r_bus_error;
    logic [CNT_W-1:0] r_stall_cycles;

    logic [7:0] w_ctl;
    logic [7:0] w_pipe_ctl;
    logic [1:0] w_next;
    logic       w_ret_md_next;
    logic       w_cnt_clr;
    logic       w_cnt_inc;
    logic       w_mem_stall;
    logic       w_md_pend;

    assign w_mem_stall = dmem_req & ~dmem_ready;
    assign w_md_pend   = md_start & ~md_done;

    // Lower-priority pipeline rules; branch beats load-use and fetch stall.
    assign w_pipe_ctl = branch_taken    ? c_ctl_branch  :
                        load_use_hazard ? c_ctl_loaduse :
                        !imem_ready     ? c_ctl_fetch   :
                                          c_ctl_advance;

    always_comb begin
        w_ctl         = c_ctl_freeze;
        w_next        = r_state;
        w_ret_md_next = r_ret_md;
        w_cnt_clr     = 1'b0;
        w_cnt_inc     = 1'b0;
        case (r_state)
            c_st_run: begin
                if (w_mem_stall) begin
                    w_next        = c_st_dmem;
                    w_ret_md_next = 1'b0;
                    w_cnt_clr     = 1'b1;
                end else if (w_md_pend) begin
                    w_ctl  = c_ctl_mdstall;
                    w_next = c_st_md;
                end else begin
                    w_ctl = w_pipe_ctl;
                end
            end
            c_st_dmem: begin
                if (!dmem_ready) begin
                    w_cnt_inc = 1'b1;
                    if (r_wait_cnt == c_timeout_last) begin
                        w_next = c_st_err;
                    end
                end else begin
                    w_ctl = w_md_pend ? c_ctl_mdstall : w_pipe_ctl;
                    // Only resume the multiply wait if the load interrupted it.
                    w_next = (r_ret_md && w_md_pend) ? c_st_md : c_st_run;
                end
            end
            c_st_md: begin
                // A memory stall in MEM can interrupt an ongoing mul/div wait.
                if (w_mem_stall) begin
                    w_next        = c_st_dmem;
                    w_ret_md_next = 1'b1;
                    w_cnt_clr     = 1'b1;
                end else if (!md_done) begin
                    w_ctl = c_ctl_mdstall;
                end else begin
                    w_ctl  = w_pipe_ctl;
                    w_next = c_st_run;
                end
            end
            default: begin
                w_next = c_st_err;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= c_st_run;
            r_ret_md       <= 1'b0;
            r_wait_cnt     <= 8'd0;
            r_bus_error    <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_next;
            r_ret_md <= w_ret_md_next;
            if (w_cnt_clr) begin
                r_wait_cnt <= 8'd0;
            end else if (w_cnt_inc) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_next == c_st_err) begin
                r_bus_error <= 1'b1;
            end
            if (!w_ctl[7] && (r_stall_cycles != {CNT_W{1'b1}})) begin
                r_stall_cycles <= r_stall_cycles + c_cnt_one;
            end
        end
    end

    // Enables and flushes are forced low for as long as reset is held.
    assign {en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, flush_mem} =
        resetn ? w_ctl : 8'd0;
    assign bus_error    = r_bus_error;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Self-checking bench for pipe_hazard_ctrl. Directed scenarios
//            followed by random traffic; a reference model pushes expected
//            outputs into a scoreboard that a monitor drains every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int SAT         = 15;

    // {en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, flush_mem}
    localparam logic [7:0] FREEZE  = 8'b00000_000;
    localparam logic [7:0] MDSTALL = 8'b00011_001;
    localparam logic [7:0] BRANCH  = 8'b11111_110;
    localparam logic [7:0] LOADUSE = 8'b00111_010;
    localparam logic [7:0] FETCH   = 8'b01111_100;
    localparam logic [7:0] ADVANCE = 8'b11111_000;

    logic clk = 1'b0;
    logic resetn, load_use_hazard, branch_taken, imem_ready;
    logic dmem_req, dmem_ready, md_start, md_done;
    logic en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, flush_mem;
    logic bus_error;
    logic [CNT_W-1:0] stall_cycles;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .load_use_hazard(load_use_hazard), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .md_start(md_start), .md_done(md_done),
        .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem), .en_wb(en_wb),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .bus_error(bus_error), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       ctl;
        logic             berr;
        logic [CNT_W-1:0] stall;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    // Reference model: what the controller is waiting on, and counters.
    bit m_mem_wait, m_md_wait, m_dead, m_back_to_md;
    int m_mem_cycles, m_stalls;

    function automatic logic [7:0] pipe_rule(bit br, bit lu, bit im);
        if (br) return BRANCH;
        if (lu) return LOADUSE;
        if (!im) return FETCH;
        return ADVANCE;
    endfunction

    // One clock cycle: drive inputs, predict outputs, advance the model.
    task automatic step(input bit rn, input bit br, input bit lu, input bit im,
                        input bit dreq, input bit drdy, input bit ms, input bit md);
        exp_t e;
        bit   mem_stall, md_pend;
        bit   n_mem, n_md, n_dead, n_back;
        int   n_cycles, n_st;
        resetn = rn; branch_taken = br; load_use_hazard = lu; imem_ready = im;
        dmem_req = dreq; dmem_ready = drdy; md_start = ms; md_done = md;
        mem_stall = dreq && !drdy;
        md_pend   = ms && !md;
        if (!rn) begin
            m_mem_wait = 0; m_md_wait = 0; m_dead = 0; m_back_to_md = 0;
            m_mem_cycles = 0; m_stalls = 0;
            e = '0;
            n_mem = 0; n_md = 0; n_dead = 0; n_back = 0; n_cycles = 0; n_st = 0;
        end else begin
            n_mem = m_mem_wait; n_md = m_md_wait; n_dead = m_dead;
            n_back = m_back_to_md; n_cycles = m_mem_cycles;
            e.berr  = m_dead;
            e.stall = CNT_W'(m_stalls);
            e.ctl   = FREEZE;
            if (m_dead) begin
                e.ctl = FREEZE;
            end else if (m_mem_wait) begin
                if (!drdy) begin
                    n_cycles = m_mem_cycles + 1;
                    if (n_cycles == MEM_TIMEOUT) begin
                        n_dead = 1; n_mem = 0;
                    end
                end else begin
                    e.ctl = md_pend ? MDSTALL : pipe_rule(br, lu, im);
                    n_mem = 0;
                    n_md  = m_back_to_md && md_pend;
                end
            end else if (m_md_wait) begin
                if (mem_stall) begin
                    n_md = 0; n_mem = 1; n_back = 1; n_cycles = 0;
                end else if (!md) begin
                    e.ctl = MDSTALL;
                end else begin
                    e.ctl = pipe_rule(br, lu, im);
                    n_md = 0;
                end
            end else begin
                if (mem_stall) begin
                    n_mem = 1; n_back = 0; n_cycles = 0;
                end else if (md_pend) begin
                    e.ctl = MDSTALL; n_md = 1;
                end else begin
                    e.ctl = pipe_rule(br, lu, im);
                end
            end
            n_st = m_stalls;
            if (!e.ctl[7] && m_stalls < SAT) n_st = m_stalls + 1;
        end
        sb.push_back(e);
        @(posedge clk);
        m_mem_wait = n_mem; m_md_wait = n_md; m_dead = n_dead;
        m_back_to_md = n_back; m_mem_cycles = n_cycles; m_stalls = n_st;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 1, 0, 0, 0, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0, 0, 0, 0);
    endtask

    // Monitor: outputs are combinational, so one expectation per cycle.
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] got;
        cyc++;
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            got = {en_if, en_id, en_ex, en_mem, en_wb, flush_id, flush_ex, flush_mem};
            n_vec++;
            if (got !== e.ctl) begin
                n_fail++;
                $display("FAIL ctl cycle %0d: got %b required %b", cyc, got, e.ctl);
            end
            n_vec++;
            if (bus_error !== e.berr) begin
                n_fail++;
                $display("FAIL bus_error cycle %0d: got %b required %b", cyc, bus_error, e.berr);
            end
            n_vec++;
            if (stall_cycles !== e.stall) begin
                n_fail++;
                $display("FAIL stall_cycles cycle %0d: got %0d required %0d", cyc, stall_cycles, e.stall);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; load_use_hazard = 0; branch_taken = 0; imem_ready = 1;
        dmem_req = 0; dmem_ready = 0; md_start = 0; md_done = 0;
        m_mem_wait = 0; m_md_wait = 0; m_dead = 0; m_back_to_md = 0;
        m_mem_cycles = 0; m_stalls = 0;
        @(posedge clk); #1;

        // Reset state, then idle flow
        do_reset(2);
        idle(5);

        // Branch together with load-use, then load-use alone
        step(1, 1, 1, 1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Data memory: three not-ready cycles then ready
        do_reset(1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0, 0);
        idle(2);

        // Data memory timeout, sticky error, reset recovery
        do_reset(1);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 1, 1, 0, 0, 0);
        idle(3);
        do_reset(1);
        idle(2);

        // Mul/div: done after five cycles
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 1, 1);
        idle(2);

        // Load stall interrupts a mul/div wait, then returns to it
        step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0, 0, 1, 1);
        idle(1);

        // dmem_ready and md_done in the same cycle
        step(1, 0, 0, 1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 1, 1, 1);
        idle(1);

        // Reset in the middle of a memory wait and of a mul/div wait
        step(1, 0, 0, 1, 1, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0);
        do_reset(1);
        idle(2);
        step(1, 0, 0, 1, 0, 0, 1, 0);
        do_reset(1);
        idle(2);

        // Stall counter saturation
        for (int i = 0; i < 20; i++) step(1, 0, 1, 1, 0, 0, 0, 0);
        idle(2);
        do_reset(1);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 80,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 40);
        end
        idle(2);

        @(negedge clk);
        #1;
        n_vec++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
